seg_scan_controller: RTL and testbench

// - Owns the 8-digit BCD entry buffer and sequences time-multiplexed scanning of the 8-common 7-segment display.
// - Accepts one decimal digit per key pulse (shift-in at digit 0), plus clear.
// - Each digit slot is split into a BLANK window (all commons off, anti-ghosting) and a DRIVE window.
// - Sits between the keypad encoder/level-to-pulse path and the display pins; replaces the free-running counter/mux scan.

---
 rtl/seg_pkg.sv | 24 ++
 rtl/seg_scan_controller_if.sv | 25 ++
 rtl/seg_scan_controller_bcd_decode.sv | 13 +
 rtl/seg_scan_controller.sv | 126 ++++++++++++
 tb/tb_seg_scan_controller.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment scan controller: digit count, BCD width,
// scan FSM state codes and the 0..9 segment pattern table ({g,f,e,d,c,b,a}).
package seg_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int BCD_W      = 4;

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_DRIVE = 1'b1;

  // Entry [n] is the active-high segment pattern for decimal digit n.
  localparam logic [9:0][6:0] SEG_TABLE = {
    7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
    7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [6:0] seg_lookup(input logic [BCD_W-1:0] code);
    logic [6:0] pat;
    pat = 7'h00;
    if (code <= 4'd9) pat = SEG_TABLE[code];
    return pat;
  endfunction

endpackage

// File: rtl/seg_scan_controller_if.sv
// Key-entry and display-pin bundle between the keypad path, the scan
// controller and the display; master drives keys, slave is the controller.
interface seg_scan_controller_if;
  import seg_pkg::*;

  logic                  key_valid;
  logic [BCD_W-1:0]      key_code;
  logic                  clear;
  logic [NUM_DIGITS-1:0] com;
  logic [6:0]            seg;
  logic [3:0]            entry_cnt;
  logic                  full;
  logic                  overflow;

  modport master (
    output key_valid, key_code, clear,
    input  com, seg, entry_cnt, full, overflow
  );

  modport slave (
    input  key_valid, key_code, clear,
    output com, seg, entry_cnt, full, overflow
  );

endinterface

// File: rtl/seg_scan_controller_bcd_decode.sv
// Combinational BCD to 7-segment decoder; codes above 9 produce a blank digit.
module seg_bcd_decode
  import seg_pkg::*;
(
  input  logic [BCD_W-1:0] bcd,
  output logic [6:0]       seg
);

  always_comb begin
    seg = seg_lookup(bcd);
  end

endmodule

// File: rtl/seg_scan_controller.sv
// 8-digit BCD entry buffer plus blank/drive time-multiplexed display scan.
// Optional build macro LEADING_ZERO_BLANK_EN suppresses unentered leading digits.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_BLANK | slot start, all commons off while segment lines settle
// ST_DRIVE | common scan_idx on, segments show digit latched at slot start
module seg_scan_controller
  import seg_pkg::*;
#(
  parameter int SLOT_CYCLES  = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  seg_scan_controller_if.slave  bus
);

  localparam int              CW         = $clog2(SLOT_CYCLES);
  localparam logic [CW-1:0]   SLOT_LAST  = CW'(SLOT_CYCLES - 1);
  localparam logic [CW-1:0]   BLANK_LAST = CW'(BLANK_CYCLES - 1);

  logic [0:0]                       state_q, state_d;
  logic [CW-1:0]                    slot_cnt_q, slot_cnt_d;
  logic [2:0]                       scan_idx_q, scan_idx_d;
  logic [BCD_W-1:0]                 cur_digit_q, cur_digit_d;
  logic [NUM_DIGITS-1:0][BCD_W-1:0] digit_buf_q, digit_buf_d;
  logic [3:0]                       entry_cnt_q, entry_cnt_d;
  logic [NUM_DIGITS-1:0]            com_q, com_d;
  logic [6:0]                       seg_q, seg_d;
  logic                             overflow_q, overflow_d;

  logic [6:0] dec_seg;
  logic       full_w;
  logic       key_ok;
  logic       lz_blank;
  logic       drive_en;

  seg_bcd_decode u_decode (
    .bcd (cur_digit_q),
    .seg (dec_seg)
  );

  assign full_w = (entry_cnt_q == 4'(NUM_DIGITS));
  assign key_ok = bus.key_valid && (bus.key_code <= 4'd9);

  always_comb begin
    state_d     = state_q;
    slot_cnt_d  = (slot_cnt_q == SLOT_LAST) ? '0 : slot_cnt_q + 1'b1;
    scan_idx_d  = scan_idx_q;
    cur_digit_d = cur_digit_q;
    if (state_q == ST_BLANK) begin
      // Digit is captured once per slot so buffer writes never tear a DRIVE window.
      if (slot_cnt_q == BLANK_LAST) begin
        state_d     = ST_DRIVE;
        cur_digit_d = digit_buf_q[scan_idx_q];
      end
    end else begin
      if (slot_cnt_q == SLOT_LAST) begin
        state_d    = ST_BLANK;
        scan_idx_d = scan_idx_q + 3'd1;
      end
    end
  end

  always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
    if (entry_cnt_q == 4'd0) lz_blank = (scan_idx_q != 3'd0);
    else                     lz_blank = ({1'b0, scan_idx_q} >= entry_cnt_q);
`else
    lz_blank = 1'b0;
`endif
    drive_en = (state_q == ST_DRIVE) && !lz_blank;
    com_d    = drive_en ? (NUM_DIGITS'(1) << scan_idx_q) : '0;
    seg_d    = drive_en ? dec_seg : 7'h00;
  end

  always_comb begin
    digit_buf_d = digit_buf_q;
    entry_cnt_d = entry_cnt_q;
    overflow_d  = 1'b0;
    // Clear takes priority and silently drops a coincident key.
    if (bus.clear) begin
      digit_buf_d = '0;
      entry_cnt_d = 4'd0;
    end else if (key_ok) begin
      if (full_w) begin
        overflow_d = 1'b1;
      end else begin
        digit_buf_d = {digit_buf_q[NUM_DIGITS-2:0], bus.key_code};
        entry_cnt_d = entry_cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_BLANK;
      slot_cnt_q  <= '0;
      scan_idx_q  <= 3'd0;
      cur_digit_q <= '0;
      digit_buf_q <= '0;
      entry_cnt_q <= 4'd0;
      com_q       <= '0;
      seg_q       <= 7'h00;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot_cnt_q  <= slot_cnt_d;
      scan_idx_q  <= scan_idx_d;
      cur_digit_q <= cur_digit_d;
      digit_buf_q <= digit_buf_d;
      entry_cnt_q <= entry_cnt_d;
      com_q       <= com_d;
      seg_q       <= seg_d;
      overflow_q  <= overflow_d;
    end
  end

  assign bus.com       = com_q;
  assign bus.seg       = seg_q;
  assign bus.entry_cnt = entry_cnt_q;
  assign bus.full      = full_w;
  assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_seg_scan_controller.sv
// Directed plus random bench for seg_scan_controller (SLOT_CYCLES=8, BLANK_CYCLES=2)
// against a cycle-indexed reference model of the scan and entry rules.
module tb_seg_scan_controller;

  localparam int SLOT   = 8;
  localparam int BLANK  = 2;
  localparam int PERIOD = 8 * SLOT;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seg_scan_controller_if sif ();

  seg_scan_controller #(
    .SLOT_CYCLES  (SLOT),
    .BLANK_CYCLES (BLANK)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .bus (sif)
  );

  logic [6:0] pat [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                          7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  int         tests = 0;
  int         fails = 0;
  int         m_buf [8];
  int         m_cnt;
  int         m_n;
  int         m_latched;
  logic [7:0] e_com;
  logic [6:0] e_seg;
  logic       e_ovf;
  bit         seg_chk;
  logic [7:0] com_seen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit shown(input int idx);
`ifdef LEADING_ZERO_BLANK_EN
    if (m_cnt == 0) return idx == 0;
    return idx < m_cnt;
`else
    return 1'b1;
`endif
  endfunction

  // Cycle n after reset: slot position (n-1)%SLOT, digit ((n-1)/SLOT)%8.
  function automatic void model_step();
    int pos;
    int idx;
    if (rst) begin
      m_n     = 0;
      m_cnt   = 0;
      m_buf   = '{default: 0};
      e_com   = 8'h00;
      e_ovf   = 1'b0;
      seg_chk = 1'b0;
      return;
    end
    m_n++;
    pos = (m_n - 1) % SLOT;
    idx = ((m_n - 1) / SLOT) % 8;
    if (pos >= BLANK && shown(idx)) begin
      e_com   = 8'(1 << idx);
      e_seg   = pat[m_latched];
      seg_chk = 1'b1;
    end else begin
      e_com   = 8'h00;
      seg_chk = 1'b0;
    end
    if (pos == BLANK - 1) m_latched = m_buf[idx];
    e_ovf = 1'b0;
    if (sif.clear) begin
      m_buf = '{default: 0};
      m_cnt = 0;
    end else if (sif.key_valid && sif.key_code <= 4'd9) begin
      if (m_cnt == 8) e_ovf = 1'b1;
      else begin
        for (int i = 7; i > 0; i--) m_buf[i] = m_buf[i-1];
        m_buf[0] = int'(sif.key_code);
        m_cnt++;
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    com_seen |= sif.com;
    check("com", sif.com, e_com);
    if (seg_chk) check("seg", sif.seg, e_seg);
    check("entry_cnt", sif.entry_cnt, m_cnt);
    check("full", sif.full, m_cnt == 8);
    check("overflow", sif.overflow, e_ovf);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic key(input int code);
    sif.key_valid = 1'b1;
    sif.key_code  = 4'(code);
    tick();
    sif.key_valid = 1'b0;
  endtask

  task automatic run_to(input int pos);
    int guard;
    guard = 0;
    do begin
      tick();
      guard++;
    end while (((m_n - 1) % PERIOD) != pos && guard < 3 * PERIOD);
    check("run_to_pos", (m_n - 1) % PERIOD, pos);
  endtask

  initial begin
    rst           = 1'b1;
    sif.key_valid = 1'b0;
    sif.key_code  = 4'd0;
    sif.clear     = 1'b0;
    m_latched     = 0;
    com_seen      = 8'h00;
    run(2);
    check("rst_com", sif.com, 8'h00);
    check("rst_seg", sif.seg, 7'h00);
    rst = 1'b0;

    // scan timing straight out of reset
    run(2);
    check("scan_blank0", sif.com, 8'h00);
    tick();
    check("scan_drive0", sif.com, 8'h01);
    run(5);
    check("scan_drive0_end", sif.com, 8'h01);
    run(3);
    check("scan_drive1", sif.com, 8'h02);
    run(48);
    check("scan_drive7", sif.com, 8'h80);
    run(8);
    check("scan_wrap", sif.com, 8'h01);

    // entry 1,2,3
    key(1); key(2); key(3);
    check("entry3_cnt", sif.entry_cnt, 4'd3);
    run_to(2);
    check("slot0_seg3", sif.seg, 7'b1001111);
    run_to(18);
    check("slot2_seg1", sif.seg, 7'b0000110);
    run(PERIOD);

    // full and overflow
    sif.clear = 1'b1; tick(); sif.clear = 1'b0;
    for (int i = 0; i < 8; i++) key(5);
    check("full_cnt", sif.entry_cnt, 4'd8);
    check("full_flag", sif.full, 1'b1);
    key(5);
    check("ovf_pulse", sif.overflow, 1'b1);
    tick();
    check("ovf_drop", sif.overflow, 1'b0);
    run(PERIOD);

    // clear beats a coincident key; invalid codes ignored
    sif.clear = 1'b1; tick(); sif.clear = 1'b0;
    key(4); key(3); key(2); key(1);
    sif.clear     = 1'b1;
    sif.key_valid = 1'b1;
    sif.key_code  = 4'd7;
    tick();
    sif.clear     = 1'b0;
    sif.key_valid = 1'b0;
    check("clr_key_cnt", sif.entry_cnt, 4'd0);
    check("clr_key_ovf", sif.overflow, 1'b0);
    key(12);
    check("bad_code_cnt", sif.entry_cnt, 4'd0);
    run(PERIOD);

    // write during slot-0 DRIVE must not change the shown digit
    run_to(3);
    key(9);
    run(2);
    check("midslot_hold", sif.seg, 7'h3F);
    run_to(2);
    check("midslot_next", sif.seg, 7'h6F);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      sif.key_valid = ($urandom_range(0, 3) == 0);
      sif.key_code  = 4'($urandom_range(0, 15));
      sif.clear     = ($urandom_range(0, 31) == 0);
      tick();
    end
    sif.key_valid = 1'b0;
    sif.clear     = 1'b0;

    // commons seen over one full period with two digits entered
    sif.clear = 1'b1; tick(); sif.clear = 1'b0;
    key(4); key(2);
    com_seen = 8'h00;
    run(PERIOD);
`ifdef LEADING_ZERO_BLANK_EN
    check("com_seen", com_seen, 8'h03);
`else
    check("com_seen", com_seen, 8'hFF);
`endif

    // reset in the middle of a DRIVE window
    run_to(20);
    rst = 1'b1;
    tick();
    check("midrst_com", sif.com, 8'h00);
    check("midrst_cnt", sif.entry_cnt, 4'd0);
    rst = 1'b0;
    run(12);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
